// File: rtl/mul8_pkg.sv
// Shared types for the multiplier back end: product width, product type and
// the accumulator state encoding.
package mul8_pkg;

    localparam int P_W = 16;

    typedef logic [P_W-1:0] prod_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/mul8_acc_stage_if.sv
// Product input stream and sum output stream of the accumulator stage.
interface mul8_acc_stage_if #(
    parameter int LEN = 16
);
    import mul8_pkg::*;

    localparam int ACC_W = P_W + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN + 1);

    prod_t              p;
    logic               p_valid;
    logic               p_last;
    logic               p_ready;
    logic [ACC_W-1:0]   s;
    logic [CNT_W-1:0]   s_cnt;
    logic               s_valid;
    logic               s_ready;

    // Upstream/downstream side: drives products, consumes sums.
    modport master (
        output p, p_valid, p_last, s_ready,
        input  p_ready, s, s_cnt, s_valid
    );

    // Accumulator side.
    modport slave (
        input  p, p_valid, p_last, s_ready,
        output p_ready, s, s_cnt, s_valid
    );

endinterface

// File: rtl/mul8_acc_oreg.sv
// Output register of the accumulator: captures a finished sum and holds it
// until the downstream side takes it.
module mul8_acc_oreg #(
    parameter int ACC_W = 20,
    parameter int CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] s_d_i,
    input  logic [CNT_W-1:0] cnt_d_i,
    input  logic             s_ready_i,
    output logic [ACC_W-1:0] s_o,
    output logic [CNT_W-1:0] s_cnt_o,
    output logic             s_valid_o
);

    logic [ACC_W-1:0] s_q;
    logic [CNT_W-1:0] s_cnt_q;
    logic             s_valid_q;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_q       <= '0;
            s_cnt_q   <= '0;
            s_valid_q <= 1'b0;
        end else if (load_i) begin
            // A reload in the same cycle as a pop keeps the output full.
            s_q       <= s_d_i;
            s_cnt_q   <= cnt_d_i;
            s_valid_q <= 1'b1;
        end else if (s_ready_i) begin
            s_valid_q <= 1'b0;
        end
    end

    assign s_o       = s_q;
    assign s_cnt_o   = s_cnt_q;
    assign s_valid_o = s_valid_q;

endmodule

// File: rtl/mul8_acc_stage.sv
// Streaming accumulator behind the 8x8 multipliers: sums up to LEN products
// per vector and emits sum plus product count on a registered valid/ready port.
module mul8_acc_stage
    import mul8_pkg::*;
#(
    parameter int LEN = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mul8_acc_stage_if.slave  bus
);

    localparam int ACC_W = P_W + $clog2(LEN);
    localparam int CNT_W = $clog2(LEN + 1);

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s_valid;
    logic             p_ready;
    logic             accept;
    logic             term;
    logic [ACC_W-1:0] sum_d;
    logic [CNT_W-1:0] cnt_d;

    assign p_ready = !s_valid || bus.s_ready;
    assign accept  = bus.p_valid && p_ready;
    assign term    = bus.p_last || (cnt_q == CNT_W'(LEN - 1));
    // The first beat of a vector starts a fresh sum regardless of acc_q.
    assign sum_d   = ((state_q == IDLE) ? '0 : acc_q) + ACC_W'(bus.p);
    assign cnt_d   = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            if (term) begin
                state_q <= IDLE;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                state_q <= ACC;
                acc_q   <= sum_d;
                cnt_q   <= cnt_d;
            end
        end
    end

    mul8_acc_oreg #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_oreg (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (accept && term),
        .s_d_i     (sum_d),
        .cnt_d_i   (cnt_d),
        .s_ready_i (bus.s_ready),
        .s_o       (bus.s),
        .s_cnt_o   (bus.s_cnt),
        .s_valid_o (s_valid)
    );

    assign bus.s_valid = s_valid;
    assign bus.p_ready = p_ready;

endmodule

// File: tb/tb_mul8_acc_stage.sv
// Directed bench for mul8_acc_stage with a scoreboard of expected sums.
module tb_mul8_acc_stage;

    localparam int LEN = 16;

    typedef struct {
        logic [19:0] s;
        logic [4:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   n_push = 0;
    int   n_pop = 0;
    exp_t sb[$];

    mul8_acc_stage_if #(.LEN(LEN)) bus ();

    mul8_acc_stage #(.LEN(LEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [19:0] s, input logic [4:0] cnt);
        exp_t e;
        e.s = s;
        e.cnt = cnt;
        sb.push_back(e);
        n_push++;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input logic [15:0] val, input logic last);
        bit done = 1'b0;
        bus.p = val;
        bus.p_last = last;
        bus.p_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.p_ready;
            @(posedge clk);
            #1;
        end
        check("beat_accepted", 32'(done), 32'd1);
    endtask

    task automatic idle();
        bus.p_valid = 1'b0;
        bus.p_last = 1'b0;
    endtask

    // Scoreboard: pop on each output transfer.
    always @(negedge clk) begin
        if (!rst && bus.s_valid && bus.s_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                check("sb_sum", 32'(bus.s), 32'(e.s));
                check("sb_cnt", 32'(bus.s_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with a valid beat offered.
        bus.p = 16'h1234;
        bus.p_valid = 1'b1;
        bus.p_last = 1'b1;
        bus.s_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_valid", 32'(bus.s_valid), 32'd0);
        check("rst_s", 32'(bus.s), 32'd0);
        check("rst_s_cnt", 32'(bus.s_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rst_p_ready", 32'(bus.p_ready), 32'd1);
        check("rst_no_output", 32'(bus.s_valid), 32'd0);
        @(posedge clk);
        #1;

        // Full vector of maximal products, LEN-th beat terminates.
        push(20'hFFFF0, 5'd16);
        for (int i = 0; i < LEN; i++) send_beat(16'hFFFF, 1'b0);
        idle();
        @(negedge clk);
        check("full_valid", 32'(bus.s_valid), 32'd1);
        check("full_sum", 32'(bus.s), 32'hFFFF0);
        check("full_cnt", 32'(bus.s_cnt), 32'd16);
        @(negedge clk);
        check("full_valid_one_cycle", 32'(bus.s_valid), 32'd0);
        @(posedge clk);
        #1;

        // Early termination, then a fresh vector.
        push(20'd15, 5'd3);
        send_beat(16'd3, 1'b0);
        send_beat(16'd5, 1'b0);
        send_beat(16'd7, 1'b1);
        push(20'd1, 5'd1);
        send_beat(16'd1, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: output held, input stalled, next beat waits.
        bus.s_ready = 1'b0;
        push(20'd4, 5'd1);
        send_beat(16'd4, 1'b1);
        bus.p = 16'd50;
        bus.p_last = 1'b1;
        push(20'd50, 5'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(bus.s_valid), 32'd1);
            check("bp_sum", 32'(bus.s), 32'd4);
            check("bp_p_ready", 32'(bus.p_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.s_ready = 1'b1;
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check("bp_resume_valid", 32'(bus.s_valid), 32'd1);
        check("bp_resume_sum", 32'(bus.s), 32'd50);
        @(posedge clk);
        #1;

        // Back-to-back single-beat vectors, no bubble.
        push(20'd100, 5'd1);
        push(20'd200, 5'd1);
        bus.p = 16'd100;
        bus.p_last = 1'b1;
        bus.p_valid = 1'b1;
        @(negedge clk);
        check("b2b_p_ready", 32'(bus.p_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.p = 16'd200;
        @(negedge clk);
        check("b2b_first_valid", 32'(bus.s_valid), 32'd1);
        check("b2b_first_sum", 32'(bus.s), 32'd100);
        check("b2b_p_ready2", 32'(bus.p_ready), 32'd1);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check("b2b_second_valid", 32'(bus.s_valid), 32'd1);
        check("b2b_second_sum", 32'(bus.s), 32'd200);
        @(posedge clk);
        #1;

        // Reset discards a pending output.
        bus.s_ready = 1'b0;
        send_beat(16'd7, 1'b1);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.s_ready = 1'b1;
        @(negedge clk);
        check("rst_pending_valid", 32'(bus.s_valid), 32'd0);
        check("rst_pending_sum", 32'(bus.s), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-vector discards the partial sum.
        for (int i = 0; i < 5; i++) send_beat(16'd1000, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(20'd9, 5'd1);
        send_beat(16'd9, 1'b1);
        idle();
        @(negedge clk);
        check("midrst_sum", 32'(bus.s), 32'd9);
        check("midrst_cnt", 32'(bus.s_cnt), 32'd1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("all_popped", 32'(n_pop), 32'(n_push));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
